matrix_ls_seq: RTL and testbench
================================

MATRIX_LS_SEQ -- requirements
Module: matrix_ls_seq

Interface
REQ-001 SHALL have parameter ROWS, default 4, matrix rows per transfer.
REQ-002 SHALL have parameter ROW_W, default 64, bits per matrix row.
REQ-003 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  decoded matrix LS op present.
REQ-007 SHALL have port req_ready  output  1  sequencer accepts op this cycle.
REQ-008 SHALL have port req_store  input  1  0 = M_LOAD, 1 = M_STORE.
REQ-009 SHALL have port req_rd  input  4  matrix register index.
REQ-010 SHALL have port req_addr  input  ADDR_W  base address (rs + imm).
REQ-011 SHALL have port req_stride  input  ADDR_W  byte offset between rows.
REQ-012 SHALL have port flush  input  1  abort in-flight op.
REQ-013 SHALL have ports mem_ren / mem_wen  output  1 each  memory read / write request.
REQ-014 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  ROW_W.
REQ-015 SHALL have ports mem_rdata  input  ROW_W, mem_ack  input  1  row transfer complete (mhit).
REQ-016 SHALL have ports rf_wen  output  1, rf_ren  output  1, rf_sel  output  4, rf_row  output  $clog2(ROWS), rf_wdata  output  ROW_W  matrix register file access.
REQ-017 SHALL have port rf_rdata  input  ROW_W  combinational row read data for rf_sel/rf_row.
REQ-018 SHALL have ports busy  output  1, done  output  1  completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, XFER, DONE.
REQ-020 req_ready SHALL be 1 only in IDLE with RST low; accept = req_valid & req_ready.
REQ-021 On accept SHALL latch store flag, rd, addr, stride; set row counter 0, cur_addr = req_addr; go XFER.
REQ-022 In XFER, load: mem_ren=1, mem_wen=0, mem_addr=cur_addr.
REQ-023 In XFER, store: mem_wen=1, mem_ren=0, mem_addr=cur_addr, rf_ren=1, rf_sel=rd, rf_row=row counter, mem_wdata=rf_rdata (same cycle).
REQ-024 Load: in the mem_ack cycle SHALL assert rf_wen=1, rf_sel=rd, rf_row=row counter, rf_wdata=mem_rdata; rf_wen SHALL be 0 otherwise.
REQ-025 mem_ack with row counter < ROWS-1: counter+1, cur_addr += stride (mod 2^ADDR_W wrap), stay XFER.
REQ-026 mem_ack with row counter = ROWS-1: go DONE.
REQ-027 No mem_ack: hold all request outputs stable; no timeout.
REQ-028 DONE SHALL assert done=1 for exactly one cycle, then IDLE; req_ready=0 in DONE.
REQ-029 busy SHALL be 1 in XFER and DONE.
REQ-030 Minimum latency: accept at cycle N, first request N+1, with continuous acks done at N+ROWS+1.
REQ-031 flush in XFER SHALL take priority over mem_ack: no rf_wen that cycle, no done, next state IDLE.
REQ-032 flush in IDLE or DONE SHALL be ignored; DONE still pulses.
REQ-033 mem_ack outside XFER SHALL be ignored.
REQ-034 stride = 0 SHALL be legal (all rows same address).
REQ-035 mem_ren, mem_wen, rf_wen, rf_ren SHALL never be asserted outside XFER.

Reset
REQ-036 RST high SHALL force IDLE, counter 0, cur_addr 0, latched fields 0 on next edge, overriding all inputs.
REQ-037 While RST high all outputs SHALL be 0, including req_ready.
REQ-038 RST mid-XFER SHALL abandon op with no done and no further rf_wen.

Verification
REQ-039 Load rd=3, addr=0x1000, stride=0x8, ack every cycle -> mem_addr 0x1000,0x1008,0x1010,0x1018 cycles N+1..N+4; rf_wen rows 0..3; done at N+5.
REQ-040 Store rd=5, addr=0x200, stride=0x40, ack every 2nd cycle -> mem_wen held with stable addr until ack; wdata=rf_rdata row k; done after 4 acks.
REQ-041 Load, flush coincident with 2nd mem_ack -> no rf_wen that cycle, no done, req_ready=1 next cycle.
REQ-042 addr=0xFFFFFFF8, stride=0x8 -> mem_addr 0xFFFFFFF8,0x0,0x8,0x10.
REQ-043 RST asserted during row 2 of a store -> next cycle IDLE, all outputs 0 while RST high, req_ready=1 after release.
REQ-044 Back-to-back req_valid held high -> second op accepted only the cycle after done.

Source files
------------

// File: rtl/matrix_ls_seq.sv
// matrix_ls_seq: sequences ROWS row transfers between memory and a matrix register file
module matrix_ls_seq #(
  parameter int ROWS = 4,
  parameter int ROW_W = 64,
  parameter int ADDR_W = 32,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [3:0]        req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_stride,
  input  logic              flush,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ROW_W-1:0]  mem_wdata,
  input  logic [ROW_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              rf_wen,
  output logic              rf_ren,
  output logic [3:0]        rf_sel,
  output logic [RW-1:0]     rf_row,
  output logic [ROW_W-1:0]  rf_wdata,
  input  logic [ROW_W-1:0]  rf_rdata,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state, state_n;
  logic store_q;
  logic [3:0] rd_q;
  logic [ADDR_W-1:0] stride_q, cur_addr;
  logic [RW-1:0] row_q;
  logic xfer, accept, adv, last;
  // every output is gated by !RST so nothing leaks while reset is held
  assign xfer = (state == XFER) && !RST;
  assign req_ready = (state == IDLE) && !RST;
  assign accept = req_valid && req_ready;
  assign adv = xfer && mem_ack && !flush;
  assign last = row_q == RW'(ROWS - 1);
  assign busy = (state != IDLE) && !RST;
  assign done = (state == DONE) && !RST;
  assign mem_ren = xfer && !store_q;
  assign mem_wen = xfer && store_q;
  assign mem_addr = xfer ? cur_addr : '0;
  assign rf_ren = xfer && store_q;
  assign rf_sel = xfer ? rd_q : '0;
  assign rf_row = xfer ? row_q : '0;
  assign mem_wdata = mem_wen ? rf_rdata : '0;
  assign rf_wen = adv && !store_q;
  assign rf_wdata = rf_wen ? mem_rdata : '0;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE)
      state_n = accept ? XFER : IDLE;
    else if (state == XFER)
      state_n = flush ? IDLE : (mem_ack && last) ? DONE : XFER;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      store_q <= 1'b0;
      rd_q <= '0;
      stride_q <= '0;
      cur_addr <= '0;
      row_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        store_q <= req_store;
        rd_q <= req_rd;
        stride_q <= req_stride;
        cur_addr <= req_addr;
        row_q <= '0;
      end else if (adv && !last) begin
        row_q <= row_q + 1'b1;
        cur_addr <= cur_addr + stride_q;
      end
    end
  end
endmodule

// File: tb/tb_matrix_ls_seq.sv
// tb_matrix_ls_seq: directed and random matrix load/store ops checked against a row-address model
module tb_matrix_ls_seq;
  localparam int ROWS = 4;
  logic CLK = 0, RST = 1;
  logic req_valid = 0, req_store = 0, flush = 0, mem_ack = 0;
  logic [3:0] req_rd = 0;
  logic [31:0] req_addr = 0, req_stride = 0;
  logic [63:0] mem_rdata = 0;
  logic req_ready, mem_ren, mem_wen, rf_wen, rf_ren, busy, done;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, rf_wdata, rf_rdata;
  logic [3:0] rf_sel;
  logic [1:0] rf_row;
  int tests = 0, fails = 0;
  logic [63:0] rf_arr [16][ROWS];
  bit wr [16][ROWS];
  logic [63:0] ref_rf [16][ROWS];

  matrix_ls_seq #(.ROWS(ROWS), .ROW_W(64), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_rd(req_rd), .req_addr(req_addr), .req_stride(req_stride), .flush(flush),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_wen(rf_wen), .rf_ren(rf_ren), .rf_sel(rf_sel),
    .rf_row(rf_row), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy), .done(done));

  always #5 CLK = ~CLK;

  function automatic logic [63:0] init_val(int s, int r);
    return {s[7:0], r[7:0], 48'h5a5a_1234_9876};
  endfunction
  function automatic logic [63:0] data_of(logic [31:0] a);
    return {a ^ 32'ha5a5_a5a5, a};
  endfunction

  // register file environment: unwritten rows read back their initial pattern
  assign rf_rdata = wr[rf_sel][rf_row] ? rf_arr[rf_sel][rf_row] : init_val(int'(rf_sel), int'(rf_row));
  always @(posedge CLK) if (rf_wen) begin
    rf_arr[rf_sel][rf_row] <= rf_wdata;
    wr[rf_sel][rf_row] <= 1'b1;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_ctl"}, {req_ready, busy, done, mem_ren, mem_wen, rf_wen, rf_ren}, 0);
    chk({tag, "_dat"}, mem_addr | rf_sel | rf_row | mem_wdata | rf_wdata, 0);
  endtask

  task automatic chk_rf(logic [3:0] rd);
    for (int r = 0; r < ROWS; r++)
      chk("rf_row", wr[rd][r] ? rf_arr[rd][r] : init_val(int'(rd), r), ref_rf[rd][r]);
  endtask

  // ackm: 0 ack every cycle, 1 ack every second cycle, 2 random ack (forced after 3 waits)
  task automatic do_op(bit st, logic [3:0] rd, logic [31:0] addr, logic [31:0] stride,
                       int ackm, int flush_k, int rst_k);
    int k = 0, w = 0;
    bit ack, fl;
    logic [31:0] a;
    req_valid = 1; req_store = st; req_rd = rd; req_addr = addr; req_stride = stride;
    @(negedge CLK); chk("accept_ready", req_ready, 1);
    @(posedge CLK); #1;
    req_valid = 0; req_rd = 4'($urandom); req_addr = $urandom; req_stride = $urandom;
    while (k < ROWS) begin
      a = addr + stride * 32'(k);
      ack = (ackm == 0) ? 1'b1 : (ackm == 1) ? (w == 1) : (w >= 3 || $urandom_range(1) == 1);
      fl = (k == flush_k) && ack;
      if (k == rst_k) begin
        RST = 1; mem_ack = 1;
        @(negedge CLK); chk_quiet("rst_mid");
        @(posedge CLK); #1;
        @(negedge CLK); chk_quiet("rst_hold");
        @(posedge CLK); #1; RST = 0; mem_ack = 0;
        @(negedge CLK); chk("rst_rel_ready", req_ready, 1); chk("rst_rel_busy", busy, 0);
        @(posedge CLK); #1;
        return;
      end
      mem_ack = ack; flush = fl; mem_rdata = data_of(a);
      @(negedge CLK);
      chk("addr", mem_addr, a);
      chk("ctl", {busy, req_ready, done, mem_ren, mem_wen, rf_ren, rf_wen},
          {3'b100, !st, st, st, !st && ack && !fl});
      if (st) begin
        chk("wdata", mem_wdata, ref_rf[rd][k]);
        chk("rsel", {rf_sel, rf_row}, {rd, 2'(k)});
      end else if (ack && !fl) begin
        chk("rf_wdata", rf_wdata, data_of(a));
        chk("wsel", {rf_sel, rf_row}, {rd, 2'(k)});
        ref_rf[rd][k] = data_of(a);
      end
      @(posedge CLK); #1;
      if (fl) begin
        mem_ack = 0; flush = 0;
        @(negedge CLK);
        chk("flush_ready", req_ready, 1); chk("flush_busy", busy, 0); chk("flush_done", done, 0);
        @(posedge CLK); #1;
        return;
      end
      if (ack) begin k++; w = 0; end else w++;
    end
    mem_ack = 1; flush = 1;
    @(negedge CLK);
    chk("done_ctl", {done, busy, req_ready, mem_ren, mem_wen, rf_wen, rf_ren}, 7'b1100000);
    @(posedge CLK); #1; mem_ack = 0; flush = 0;
    @(negedge CLK);
    chk("after_done", {done, busy, req_ready}, 3'b001);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < ROWS; r++) ref_rf[s][r] = init_val(s, r);
    req_valid = 1; mem_ack = 1; flush = 1;
    @(negedge CLK); chk_quiet("reset");
    @(posedge CLK); #1;
    @(negedge CLK); chk_quiet("reset2");
    @(posedge CLK); #1; RST = 0; req_valid = 0; mem_ack = 0; flush = 0;
    @(negedge CLK);
    chk("idle", {req_ready, busy, done, mem_ren, mem_wen}, 5'b10000);
    @(posedge CLK); #1;
    do_op(0, 3, 32'h1000, 32'h8, 0, -1, -1); chk_rf(3);
    do_op(1, 5, 32'h200, 32'h40, 1, -1, -1);
    do_op(0, 9, 32'h3000, 32'h10, 0, 1, -1); chk_rf(9);
    do_op(0, 2, 32'hFFFF_FFF8, 32'h8, 0, -1, -1); chk_rf(2);
    do_op(1, 3, 32'h4000, 32'h20, 0, -1, 2);
    do_op(1, 3, 32'h5000, 32'h0, 2, -1, -1);
    // back-to-back: req_valid held, second op accepted the cycle after done
    req_valid = 1; req_store = 0; req_rd = 7; req_addr = 32'h80; req_stride = 4;
    mem_ack = 1; mem_rdata = 64'hdead_beef_0bad_f00d;
    for (int c = 0; c <= 12; c++) begin
      @(negedge CLK);
      chk("b2b_ready", req_ready, (c == 0 || c == 6 || c == 12));
      chk("b2b_done", done, (c == 5 || c == 11));
      @(posedge CLK); #1;
      if (c == 6) req_valid = 0;
    end
    mem_ack = 0;
    for (int r = 0; r < ROWS; r++) ref_rf[7][r] = 64'hdead_beef_0bad_f00d;
    chk_rf(7);
    for (int i = 0; i < 14; i++) begin
      logic [3:0] rd;
      bit st;
      rd = 4'($urandom);
      st = 1'($urandom_range(1));
      do_op(st, rd, $urandom, ($urandom_range(3) == 0) ? 32'h0 : $urandom,
            2, ($urandom_range(4) == 0) ? int'($urandom_range(ROWS - 1)) : -1, -1);
      if (!st) chk_rf(rd);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
